pong_ball_engine: RTL and testbench
===================================

// Module: pong_ball_engine
// PURPOSE
//  Ball motion/scoring core of the Pong datapath. Advances the ball once per game tick, bounces it off
//  the top/bottom walls and both paddles, detects misses, and keeps the score. Upstream: Debouncer-clean
//  serve button and a 1-cycle tick strobe derived from game_clock_generator. Downstream: ball_x/ball_y
//  feed offset_check2D for pixel rendering.
// PARAMETERS
//  WIDTH          10   coordinate width (bits)
//  SCREEN_W       640  playfield width (px)
//  SCREEN_H       480  playfield height (px)
//  BALL_SIZE      8    ball edge length (px, square)
//  PADDLE_W       8    paddle width (px)
//  PADDLE_H       48   paddle height (px)
//  LEFT_PADDLE_X  16   left paddle left edge (px)
//  RIGHT_PADDLE_X 616  right paddle left edge (px)
//  SPEED          2    px moved per tick on each axis
//  SERVE_DELAY    16   ticks from serve/score to motion
//  WIN_SCORE      7    points that end the game
// PORTS
//  clk              in   1      system clock
//  reset            in   1      asynchronous, active-high
//  tick             in   1      1-cycle game-tick strobe
//  serve            in   1      1-cycle serve request (debounced, edge-detected upstream)
//  left_paddle_top  in   WIDTH  left paddle top row
//  right_paddle_top in   WIDTH  right paddle top row
//  ball_x, ball_y   out  WIDTH  ball top-left corner
//  ball_active      out  1      1 only in MOVE
//  score_left       out  4      left player points
//  score_right      out  4      right player points
//  game_over        out  1      1 in GAME_OVER
// BEHAVIOUR
//  Clock is clk; reset is asynchronous, active-high. All state is in registers; outputs come straight from registers.
//  Reset values: state=IDLE, ball_x=(SCREEN_W-BALL_SIZE)/2=316, ball_y=(SCREEN_H-BALL_SIZE)/2=236.
//   Also dx=right, dy=down, scores=0, ball_active=0, game_over=0, countdown=0.
//  Reset mid-operation returns everything to these values immediately.
//  States:
//   IDLE:      ball centred. serve -> SERVE_WAIT with countdown=SERVE_DELAY. tick is ignored.
//   SERVE_WAIT: each tick decrements countdown. On the tick that reaches 0 -> MOVE. The ball does not move on that tick.
//   MOVE:      on each tick, compute nx=x±SPEED and ny=y±SPEED. Evaluate each axis independently in the same tick.
//    Y axis:
//     - down and ny+BALL_SIZE>SCREEN_H: y=SCREEN_H-BALL_SIZE, dy flips.
//     - up and y<SPEED: y=0, dy flips.
//    X axis, right paddle (moving right):
//     - hit when x+BALL_SIZE<=RIGHT_PADDLE_X and nx+BALL_SIZE>RIGHT_PADDLE_X,
//       and ny+BALL_SIZE>right_paddle_top and ny<right_paddle_top+PADDLE_H.
//     - on hit: x=RIGHT_PADDLE_X-BALL_SIZE, dx flips.
//    X axis, left paddle (moving left): mirror image.
//     - hit when x>=LEFT_PADDLE_X+PADDLE_W, nx<LEFT_PADDLE_X+PADDLE_W, and the same overlap test against left_paddle_top.
//     - on hit: x=LEFT_PADDLE_X+PADDLE_W, dx flips.
//    Miss:
//     - right: x+BALL_SIZE+SPEED>SCREEN_W -> score_left++, -> SCORED.
//     - left: x<SPEED -> score_right++, -> SCORED.
//     - The ball does not move on a miss tick.
//   SCORED (1 cycle):
//    - ball recentred; dx points toward the player who conceded; dy is kept.
//    - if either score==WIN_SCORE -> GAME_OVER, else -> SERVE_WAIT with countdown=SERVE_DELAY.
//   GAME_OVER: game_over=1, ball centred, scores held.
//    - serve clears both scores and dx=right, then -> SERVE_WAIT.
//  serve is ignored outside IDLE and GAME_OVER. If serve and tick arrive in the same cycle in IDLE/GAME_OVER, serve wins and tick is dropped.
//  A tick with no state change holds all registers. Paddle inputs are sampled only on MOVE ticks.
//  Arithmetic uses WIDTH+1 bits so that bounds compares cannot wrap. Scores cannot exceed WIN_SCORE.
// TESTING
//  T1 reset asserted mid-MOVE -> immediately (316,236), IDLE, scores 0, ball_active=0, game_over=0.
//  T2 serve, then 16 ticks -> ball_active=1 after tick 16, ball still (316,236).
//     Next tick -> (318,238).
//  T3 right_paddle_top=400, run MOVE ticks:
//     - tick 118: y=472.
//     - tick 119: y holds 472, dy=up.
//     - tick 147: ball_x=608 (clamped), dx=left.
//     - tick 148: ball_x=606.
//  T4 right_paddle_top=0 -> no hit at tick 147. Tick 158: ball_x=632.
//     Tick 159: score_left=1, ball_active=0, ball=(316,y) with dx=right, then 16 ticks -> MOVE.
//  T5 left_paddle_top tracking the ball, right_paddle_top=0, repeat misses:
//     - score_left reaches 7 -> game_over=1, tick ignored.
//     - serve -> scores 0, SERVE_WAIT.
//  T6 serve pulses during SERVE_WAIT/MOVE -> no effect. serve+tick in the same cycle in IDLE -> SERVE_WAIT, countdown=16.

Source files
------------

// File: rtl/pong_if.sv
// Pong ball engine bus: game-tick/serve strobes and paddle rows in,
// ball position, status and scores out.
//   master: drives tick, serve, left_paddle_top, right_paddle_top
//   slave : drives ball_x, ball_y, ball_active, score_left, score_right, game_over
interface pong_if #(
  parameter int unsigned WIDTH = 10
) ();
  logic             tick;
  logic             serve;
  logic [WIDTH-1:0] left_paddle_top;
  logic [WIDTH-1:0] right_paddle_top;
  logic [WIDTH-1:0] ball_x;
  logic [WIDTH-1:0] ball_y;
  logic             ball_active;
  logic [3:0]       score_left;
  logic [3:0]       score_right;
  logic             game_over;

  modport master (
    output tick, serve, left_paddle_top, right_paddle_top,
    input  ball_x, ball_y, ball_active, score_left, score_right, game_over
  );

  modport slave (
    input  tick, serve, left_paddle_top, right_paddle_top,
    output ball_x, ball_y, ball_active, score_left, score_right, game_over
  );
endinterface

// File: rtl/pong_ball_engine.sv
// Pong ball motion and scoring core: moves the ball once per game tick,
// bounces it off walls and paddles, detects misses and keeps the score.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pong_if slave (tick/serve/paddle rows in; ball position,
//                ball_active, scores, game_over out -- all registered)
module pong_ball_engine #(
  parameter int unsigned WIDTH          = 10,
  parameter int unsigned SCREEN_W       = 640,
  parameter int unsigned SCREEN_H       = 480,
  parameter int unsigned BALL_SIZE      = 8,
  parameter int unsigned PADDLE_W       = 8,
  parameter int unsigned PADDLE_H       = 48,
  parameter int unsigned LEFT_PADDLE_X  = 16,
  parameter int unsigned RIGHT_PADDLE_X = 616,
  parameter int unsigned SPEED          = 2,
  parameter int unsigned SERVE_DELAY    = 16,
  parameter int unsigned WIN_SCORE      = 7
) (
  input logic   clk,
  input logic   reset,
  pong_if.slave bus
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(SERVE_DELAY + 1);
  localparam logic [WIDTH-1:0] CENTER_X = WIDTH'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [WIDTH-1:0] CENTER_Y = WIDTH'((SCREEN_H - BALL_SIZE) / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SERVE_WAIT, S_MOVE, S_SCORED, S_GAME_OVER
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic             dx_q, dx_d;   // 1 = moving right
  logic             dy_q, dy_d;   // 1 = moving down
  logic [3:0]       score_l_q, score_l_d, score_r_q, score_r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d, game_over_q, game_over_d;

  // Candidate position and collision predicates, one bit wider so nothing wraps
  logic [AW-1:0] x_w, y_w, nx, ny, lpt_w, rpt_w;
  logic          miss_right, miss_left, hit_right, hit_left, y_bot, y_top;

  assign x_w   = AW'(x_q);
  assign y_w   = AW'(y_q);
  assign lpt_w = AW'(bus.left_paddle_top);
  assign rpt_w = AW'(bus.right_paddle_top);
  assign nx    = dx_q ? x_w + AW'(SPEED) : x_w - AW'(SPEED);
  assign ny    = dy_q ? y_w + AW'(SPEED) : y_w - AW'(SPEED);

  assign miss_right = dx_q  && (x_w + AW'(BALL_SIZE + SPEED) > AW'(SCREEN_W));
  assign miss_left  = !dx_q && (x_w < AW'(SPEED));
  assign hit_right  = dx_q
                   && (x_w + AW'(BALL_SIZE) <= AW'(RIGHT_PADDLE_X))
                   && (nx + AW'(BALL_SIZE) > AW'(RIGHT_PADDLE_X))
                   && (ny + AW'(BALL_SIZE) > rpt_w)
                   && (ny < rpt_w + AW'(PADDLE_H));
  assign hit_left   = !dx_q
                   && (x_w >= AW'(LEFT_PADDLE_X + PADDLE_W))
                   && (nx < AW'(LEFT_PADDLE_X + PADDLE_W))
                   && (ny + AW'(BALL_SIZE) > lpt_w)
                   && (ny < lpt_w + AW'(PADDLE_H));
  assign y_bot      = dy_q  && (ny + AW'(BALL_SIZE) > AW'(SCREEN_H));
  assign y_top      = !dy_q && (y_w < AW'(SPEED));

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= CENTER_X;
      y_q         <= CENTER_Y;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      score_l_q   <= '0;
      score_r_q   <= '0;
      cnt_q       <= '0;
      active_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.serve) begin
          state_d = S_SERVE_WAIT;
          cnt_d   = CW'(SERVE_DELAY);
        end
      end
      S_SERVE_WAIT: begin
        if (bus.tick) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        if (bus.tick) begin
          if (miss_right) begin
            if (score_l_q < 4'(WIN_SCORE)) score_l_d = score_l_q + 4'd1;
            state_d = S_SCORED;
          end else if (miss_left) begin
            if (score_r_q < 4'(WIN_SCORE)) score_r_d = score_r_q + 4'd1;
            state_d = S_SCORED;
          end else begin
            if (y_bot) begin
              y_d  = WIDTH'(SCREEN_H - BALL_SIZE);
              dy_d = 1'b0;
            end else if (y_top) begin
              y_d  = '0;
              dy_d = 1'b1;
            end else begin
              y_d = ny[WIDTH-1:0];
            end
            if (hit_right) begin
              x_d  = WIDTH'(RIGHT_PADDLE_X - BALL_SIZE);
              dx_d = 1'b0;
            end else if (hit_left) begin
              x_d  = WIDTH'(LEFT_PADDLE_X + PADDLE_W);
              dx_d = 1'b1;
            end else begin
              x_d = nx[WIDTH-1:0];
            end
          end
        end
      end
      S_SCORED: begin
        // The ball was travelling toward the conceding side, so dx already
        // points at that player; only the position is recentred.
        x_d = CENTER_X;
        y_d = CENTER_Y;
        if (score_l_q == 4'(WIN_SCORE) || score_r_q == 4'(WIN_SCORE)) begin
          state_d = S_GAME_OVER;
        end else begin
          state_d = S_SERVE_WAIT;
          cnt_d   = CW'(SERVE_DELAY);
        end
      end
      S_GAME_OVER: begin
        x_d = CENTER_X;
        y_d = CENTER_Y;
        if (bus.serve) begin
          score_l_d = '0;
          score_r_d = '0;
          dx_d      = 1'b1;
          state_d   = S_SERVE_WAIT;
          cnt_d     = CW'(SERVE_DELAY);
        end
      end
      default: state_d = S_IDLE;
    endcase

    active_d    = (state_d == S_MOVE);
    game_over_d = (state_d == S_GAME_OVER);
  end

  assign bus.ball_x      = x_q;
  assign bus.ball_y      = y_q;
  assign bus.ball_active = active_q;
  assign bus.score_left  = score_l_q;
  assign bus.score_right = score_r_q;
  assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine: a behavioural game model feeds a
// scoreboard compared every cycle, plus a table of hand-derived checkpoints
// and short hand-written sequences for serve/reset/game-over corners.
module tb_pong_ball_engine;

  logic clk = 1'b0;
  logic reset;
  pong_if #(.WIDTH(10)) bus ();

  pong_ball_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; bit act; int sl; int sr; bit go;
  } exp_t;

  typedef struct {
    bit rst; int n; bit sv; bit tk; int rpt;
    int ex; int ey; bit eact; int esl; int esr; bit ego;
  } row_t;

  localparam int M_IDLE = 0, M_WAIT = 1, M_MOVE = 2, M_SCORED = 3, M_GO = 4;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  row_t rows[19];

  int m_st, m_x, m_y, m_sl, m_sr, m_cnt;
  bit m_dx, m_dy;

  task automatic model_reset();
    m_st = M_IDLE; m_x = 316; m_y = 236; m_dx = 1; m_dy = 1;
    m_sl = 0; m_sr = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit sv, input bit tk, input int lpt, input int rpt);
    int nx, ny;
    bit ovl_r, ovl_l;
    case (m_st)
      M_IDLE: if (sv) begin m_st = M_WAIT; m_cnt = 16; end
      M_WAIT: if (tk) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_st = M_MOVE;
      end
      M_MOVE: if (tk) begin
        nx = (m_dx ? m_x + 2 : m_x - 2) & 'h7FF;
        ny = (m_dy ? m_y + 2 : m_y - 2) & 'h7FF;
        if (m_dx && m_x + 10 > 640) begin
          if (m_sl < 7) m_sl = m_sl + 1;
          m_st = M_SCORED;
        end else if (!m_dx && m_x < 2) begin
          if (m_sr < 7) m_sr = m_sr + 1;
          m_st = M_SCORED;
        end else begin
          ovl_r = (((ny + 8) & 'h7FF) > rpt) && (ny < rpt + 48);
          ovl_l = (((ny + 8) & 'h7FF) > lpt) && (ny < lpt + 48);
          if (m_dy && ny + 8 > 480) begin m_y = 472; m_dy = 0; end
          else if (!m_dy && m_y < 2) begin m_y = 0; m_dy = 1; end
          else m_y = ny;
          if (m_dx && m_x + 8 <= 616 && nx + 8 > 616 && ovl_r) begin
            m_x = 608; m_dx = 0;
          end else if (!m_dx && m_x >= 24 && nx < 24 && ovl_l) begin
            m_x = 24; m_dx = 1;
          end else begin
            m_x = nx;
          end
        end
      end
      M_SCORED: begin
        m_x = 316; m_y = 236;
        if (m_sl == 7 || m_sr == 7) m_st = M_GO;
        else begin m_st = M_WAIT; m_cnt = 16; end
      end
      M_GO: begin
        m_x = 316; m_y = 236;
        if (sv) begin m_sl = 0; m_sr = 0; m_dx = 1; m_st = M_WAIT; m_cnt = 16; end
      end
      default: m_st = M_IDLE;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.x = m_x; e.y = m_y; e.act = (m_st == M_MOVE);
    e.sl = m_sl; e.sr = m_sr; e.go = (m_st == M_GO);
    return e;
  endfunction

  function automatic int track(input int y);
    int t;
    t = y - 20;
    if (t < 0) t = 0;
    if (t > 432) t = 432;
    return t;
  endfunction

  function automatic int avoid(input int y);
    return (y < 240) ? 400 : 0;
  endfunction

  task automatic check_out(input string name, input exp_t e);
    bit bad;
    checks++;
    bad = (int'(bus.ball_x) != e.x) || (e.y >= 0 && int'(bus.ball_y) != e.y) ||
          (bus.ball_active != e.act) || (int'(bus.score_left) != e.sl) ||
          (int'(bus.score_right) != e.sr) || (bus.game_over != e.go);
    if (bad) begin
      errors++;
      $display("FAIL %s t=%0t: got x=%0d y=%0d act=%0b sl=%0d sr=%0d go=%0b, expected x=%0d y=%0d act=%0b sl=%0d sr=%0d go=%0b",
               name, $time, bus.ball_x, bus.ball_y, bus.ball_active, bus.score_left,
               bus.score_right, bus.game_over, e.x, e.y, e.act, e.sl, e.sr, e.go);
    end
  endtask

  task automatic check_hand(input string name, input int x, input int y, input bit act,
                            input int sl, input int sr, input bit go);
    exp_t e;
    e.x = x; e.y = y; e.act = act; e.sl = sl; e.sr = sr; e.go = go;
    check_out(name, e);
  endtask

  // Drive one cycle, push the model's expectation, compare after the edge
  task automatic step(input bit sv, input bit tk, input int lpt, input int rpt);
    exp_t e;
    @(negedge clk);
    bus.serve = sv; bus.tick = tk;
    bus.left_paddle_top = 10'(lpt); bus.right_paddle_top = 10'(rpt);
    model_step(sv, tk, lpt, rpt);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_out("scoreboard", e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_hand("reset_async", 316, 236, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_sr, cyc;

    rows[0]  = '{1, 1,   1, 0, 0,   316, 236, 0, 0, 0, 0};
    rows[1]  = '{0, 15,  0, 1, 0,   316, 236, 0, 0, 0, 0};
    rows[2]  = '{0, 1,   0, 1, 0,   316, 236, 1, 0, 0, 0};
    rows[3]  = '{0, 1,   0, 1, 0,   318, 238, 1, 0, 0, 0};
    rows[4]  = '{0, 117, 0, 1, 0,   552, 472, 1, 0, 0, 0};
    rows[5]  = '{0, 1,   0, 1, 0,   554, 472, 1, 0, 0, 0};
    rows[6]  = '{0, 27,  0, 1, 400, 608, 418, 1, 0, 0, 0};
    rows[7]  = '{0, 1,   0, 1, 400, 608, 416, 1, 0, 0, 0};
    rows[8]  = '{0, 1,   0, 1, 400, 606, 414, 1, 0, 0, 0};
    rows[9]  = '{1, 1,   1, 0, 0,   316, 236, 0, 0, 0, 0};
    rows[10] = '{0, 16,  0, 1, 0,   316, 236, 1, 0, 0, 0};
    rows[11] = '{0, 146, 0, 1, 0,   608, 418, 1, 0, 0, 0};
    rows[12] = '{0, 1,   0, 1, 0,   610, 416, 1, 0, 0, 0};
    rows[13] = '{0, 11,  0, 1, 0,   632, 394, 1, 0, 0, 0};
    rows[14] = '{0, 1,   0, 1, 0,   632, 394, 0, 1, 0, 0};
    rows[15] = '{0, 1,   0, 1, 0,   316, -1,  0, 1, 0, 0};
    rows[16] = '{0, 15,  0, 1, 0,   316, -1,  0, 1, 0, 0};
    rows[17] = '{0, 1,   0, 1, 0,   316, -1,  1, 1, 0, 0};
    rows[18] = '{0, 1,   0, 1, 0,   318, -1,  1, 1, 0, 0};

    reset = 1'b1;
    bus.tick = 1'b0; bus.serve = 1'b0;
    bus.left_paddle_top = '0; bus.right_paddle_top = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_hand("reset_state", 316, 236, 0, 0, 0, 0);
    reset = 1'b0;

    // Serve latency, wall bounce, right paddle hit/miss, scoring
    for (int i = 0; i < 19; i++) begin
      if (rows[i].rst) do_reset();
      for (int k = 0; k < rows[i].n; k++) step(rows[i].sv, rows[i].tk, 0, rows[i].rpt);
      check_hand($sformatf("row%0d", i), rows[i].ex, rows[i].ey, rows[i].eact,
                 rows[i].esl, rows[i].esr, rows[i].ego);
    end

    // Serve during MOVE is ignored, ball keeps moving
    step(1, 1, 0, 0);
    check_hand("serve_in_move", 320, -1, 1, 1, 0, 0);

    // Serve during SERVE_WAIT does not restart the countdown
    do_reset();
    step(1, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    repeat (10) step(0, 1, 0, 0);
    check_hand("serve_in_wait_15", 316, 236, 0, 0, 0, 0);
    step(0, 1, 0, 0);
    check_hand("serve_in_wait_16", 316, 236, 1, 0, 0, 0);

    // Serve and tick together in IDLE: serve wins, full countdown follows
    do_reset();
    step(1, 1, 0, 0);
    check_hand("serve_tick_idle", 316, 236, 0, 0, 0, 0);
    repeat (15) step(0, 1, 0, 0);
    check_hand("idle_countdown_15", 316, 236, 0, 0, 0, 0);
    step(0, 1, 0, 0);
    check_hand("idle_countdown_16", 316, 236, 1, 0, 0, 0);

    // Rally with both paddles tracking the ball
    repeat (1200) step(0, 1, track(m_y), track(m_y));

    // Left paddle steps away: left miss scores for the right player
    start_sr = m_sr;
    cyc = 0;
    while (m_sr == start_sr && cyc < 3000) begin
      step(0, 1, avoid(m_y), track(m_y));
      cyc++;
    end
    checks++;
    if (int'(bus.score_right) != start_sr + 1) begin
      errors++;
      $display("FAIL left_miss: got score_right=%0d, expected %0d", bus.score_right, start_sr + 1);
    end

    // Right paddle avoids the ball until the left player wins
    cyc = 0;
    while (m_st != M_GO && cyc < 20000) begin
      step(0, 1, track(m_y), avoid(m_y));
      cyc++;
    end
    check_hand("game_over", 316, 236, 0, 7, m_sr, 1);
    step(0, 1, 0, 0);
    check_hand("game_over_tick", 316, 236, 0, 7, m_sr, 1);
    step(1, 1, 0, 0);
    check_hand("game_over_serve", 316, 236, 0, 0, 0, 0);
    repeat (15) step(0, 1, 0, 0);
    check_hand("restart_wait", 316, 236, 0, 0, 0, 0);
    step(0, 1, 0, 0);
    check_hand("restart_move", 316, 236, 1, 0, 0, 0);
    step(0, 1, 0, 0);
    check_hand("restart_dx_right", 318, -1, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
